cpu_control_fsm: RTL and testbench

Multicycle control sequencer for the 16-bit teaching processor datapath. It fetches instructions, decodes the opcode field of the instruction register and drives every datapath strobe. That includes the address-source select of the 2:1 memory-address mux: PC or register A. It also handshakes with the memory port and supervises memory latency with a timeout.

---
 rtl/cpu_control_fsm.sv | 157 +++++++++++++++
 tb/tb_cpu_control_fsm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multicycle control sequencer: fetch/decode/execute with a memory handshake
// and a request-latency timeout that parks the machine in HALT.
module cpu_control_fsm #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        addr_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        rf_we,
  output logic        rf_wsel,
  output logic [1:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        mem_err
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpLd   = 4'd3;
  localparam logic [3:0] OpSt   = 4'd4;
  localparam logic [3:0] OpBeqz = 4'd5;
  localparam logic [3:0] OpJmp  = 4'd6;
  localparam logic [3:0] OpHalt = 4'd7;

  // Counter value seen on the last permitted request cycle without ack.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [3:0] opcode;

  assign opcode = ir[15:12];

  // State, timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    addr_sel = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    rf_we    = 1'b0;
    rf_wsel  = 1'b0;
    alu_op   = 2'b00;
    case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
          cnt_d   = 8'd0;
        end
      end
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = StDecode;
        end else if (cnt_q == CntLast) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDecode: begin
        cnt_d = 8'd0;
        case (opcode)
          OpAdd, OpSub, OpAnd, OpBeqz, OpJmp: state_d = StExec;
          OpLd, OpSt:                         state_d = StMem;
          OpHalt:                             state_d = StHalt;
          default:                            state_d = StFetch;
        endcase
      end
      StExec: begin
        case (opcode)
          OpAdd, OpSub, OpAnd: begin
            alu_op = opcode[1:0];
            rf_we  = 1'b1;
          end
          OpJmp:   pc_load = 1'b1;
          OpBeqz:  pc_load = zero;
          default: ;
        endcase
        state_d = StFetch;
        cnt_d   = 8'd0;
      end
      StMem: begin
        addr_sel = 1'b1;
        mem_req  = 1'b1;
        mem_we   = (opcode == OpSt);
        if (mem_ack) begin
          if (opcode == OpLd) begin
            rf_we   = 1'b1;
            rf_wsel = 1'b1;
          end
          state_d = StFetch;
          cnt_d   = 8'd0;
        end else if (cnt_q == CntLast) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHalt: begin
        if (run) begin
          state_d = StFetch;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy    = (state_q != StIdle) && (state_q != StHalt);
    halted  = (state_q == StHalt);
    mem_err = err_q;
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm; all outputs are packed into one vector
// and compared each cycle against hand-written expectations.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic        zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        addr_sel, mem_req, mem_we, ir_load, pc_inc, pc_load;
  logic        rf_we, rf_wsel, busy, halted, mem_err;
  logic [1:0]  alu_op;

  int tests = 0;
  int fails = 0;

  localparam logic [12:0] AS  = 13'h1000;
  localparam logic [12:0] REQ = 13'h0800;
  localparam logic [12:0] WE  = 13'h0400;
  localparam logic [12:0] IRL = 13'h0200;
  localparam logic [12:0] PCI = 13'h0100;
  localparam logic [12:0] PCL = 13'h0080;
  localparam logic [12:0] RFW = 13'h0040;
  localparam logic [12:0] RFS = 13'h0020;
  localparam logic [12:0] BSY = 13'h0004;
  localparam logic [12:0] HLT = 13'h0002;
  localparam logic [12:0] ERR = 13'h0001;

  logic [12:0] outs;
  assign outs = {addr_sel, mem_req, mem_we, ir_load, pc_inc, pc_load, rf_we, rf_wsel,
                 alu_op, busy, halted, mem_err};

  cpu_control_fsm #(.TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn), .run(run), .ir(ir), .zero(zero), .mem_ack(mem_ack),
    .addr_sel(addr_sel), .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .alu_op(alu_op), .busy(busy), .halted(halted), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs after the falling edge, then let outputs settle.
  task automatic cyc(input logic r, input logic a);
    @(negedge clk);
    run = r;
    mem_ack = a;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    run = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] exp_v [4];
    @(negedge clk);
    #1;
    tests++;
    if (outs !== 13'h0) begin
      $display("FAIL reset_hold: got %h want %h", outs, 13'h0); fails++;
    end
    resetn = 1'b1;
    cyc(1'b1, 1'b0);            // IDLE, run sampled
    cyc(1'b0, 1'b0);            // FETCH waiting
    tests++;
    if (outs !== (REQ | BSY)) begin
      $display("FAIL reset_fetch: got %h want %h", outs, REQ | BSY); fails++;
    end
    #2 resetn = 1'b0;           // asynchronous reset mid-FETCH
    #1;
    tests++;
    if (outs !== 13'h0) begin
      $display("FAIL reset_async: got %h want %h", outs, 13'h0); fails++;
    end
    @(negedge clk);
    resetn = 1'b1;
    exp_v = '{13'h0, 13'h0, 13'h0, 13'h0};
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1);          // ack with no request must be ignored
      tests++;
      if (outs !== exp_v[i]) begin
        $display("FAIL reset_idle%0d: got %h want %h", i, outs, exp_v[i]); fails++;
      end
    end
  endtask

  task automatic test_alu();
    logic [12:0] exp_v [5];
    for (int op = 0; op < 3; op++) begin
      do_reset();
      ir = {4'(op), 12'h123};
      exp_v = '{13'h0, REQ | IRL | PCI | BSY, BSY, RFW | BSY | 13'(op << 3), REQ | BSY};
      for (int c = 0; c < 5; c++) begin
        // run during EXEC and ack during DECODE must both be ignored
        cyc(c == 0 || c == 3, c == 1 || c == 2);
        tests++;
        if (outs !== exp_v[c]) begin
          $display("FAIL alu op%0d cyc%0d: got %h want %h", op, c, outs, exp_v[c]); fails++;
        end
      end
    end
  endtask

  task automatic test_ld();
    logic [12:0] exp_v [7];
    logic        ack_v [7];
    do_reset();
    ir = 16'h3456;
    exp_v = '{13'h0, REQ | IRL | PCI | BSY, BSY, AS | REQ | BSY, AS | REQ | BSY,
              AS | REQ | RFW | RFS | BSY, REQ | BSY};
    ack_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 7; c++) begin
      cyc(c == 0, ack_v[c]);
      tests++;
      if (outs !== exp_v[c]) begin
        $display("FAIL ld cyc%0d: got %h want %h", c, outs, exp_v[c]); fails++;
      end
    end
  endtask

  task automatic test_st();
    logic [12:0] exp_v [5];
    do_reset();
    ir = 16'h4abc;
    exp_v = '{13'h0, REQ | IRL | PCI | BSY, BSY, AS | REQ | WE | BSY, REQ | BSY};
    for (int c = 0; c < 5; c++) begin
      cyc(c == 0, c == 1 || c == 3);
      tests++;
      if (outs !== exp_v[c]) begin
        $display("FAIL st cyc%0d: got %h want %h", c, outs, exp_v[c]); fails++;
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] ir_v [3];
    logic        z_v [3];
    logic [12:0] exp_v [3];
    ir_v = '{16'h5000, 16'h5000, 16'h6000};
    z_v = '{1'b0, 1'b1, 1'b0};
    exp_v = '{BSY, PCL | BSY, PCL | BSY};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      ir = ir_v[t];
      zero = z_v[t];
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      tests++;
      if (outs !== exp_v[t]) begin
        $display("FAIL branch%0d exec: got %h want %h", t, outs, exp_v[t]); fails++;
      end
    end
    zero = 1'b0;
    // Illegal opcode: FETCH, DECODE, then straight back to FETCH
    do_reset();
    ir = 16'h9000;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    tests++;
    if (outs !== (REQ | BSY)) begin
      $display("FAIL illegal: got %h want %h", outs, REQ | BSY); fails++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ir = 16'h0000;
    cyc(1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cyc(c == 1, 1'b0);        // run while busy is ignored
      tests++;
      if (outs !== (REQ | BSY)) begin
        $display("FAIL timeout wait%0d: got %h want %h", c, outs, REQ | BSY); fails++;
      end
    end
    cyc(1'b1, 1'b0);
    tests++;
    if (outs !== (HLT | ERR)) begin
      $display("FAIL timeout halt: got %h want %h", outs, HLT | ERR); fails++;
    end
    cyc(1'b0, 1'b0);
    tests++;
    if (outs !== (REQ | BSY)) begin
      $display("FAIL timeout restart: got %h want %h", outs, REQ | BSY); fails++;
    end
    // Timeout in MEM on a load: no register write, ends in HALT
    do_reset();
    ir = 16'h3000;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, 1'b0);
      tests++;
      if (outs !== (AS | REQ | BSY)) begin
        $display("FAIL memto wait%0d: got %h want %h", c, outs, AS | REQ | BSY); fails++;
      end
    end
    cyc(1'b0, 1'b1);
    tests++;
    if (outs !== (HLT | ERR)) begin
      $display("FAIL memto halt: got %h want %h", outs, HLT | ERR); fails++;
    end
  endtask

  task automatic test_halt();
    logic [12:0] exp_v [5];
    do_reset();
    ir = 16'h7000;
    exp_v = '{13'h0, REQ | IRL | PCI | BSY, BSY, HLT, HLT};
    for (int c = 0; c < 5; c++) begin
      cyc(c == 0, c == 1);
      tests++;
      if (outs !== exp_v[c]) begin
        $display("FAIL halt cyc%0d: got %h want %h", c, outs, exp_v[c]); fails++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ld();
    test_st();
    test_branch();
    test_timeout();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
